uart_rx_frame: RTL and testbench
================================

UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27: clock cycles per 1/16-bit oversample tick; legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clock, input, 1: single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port rx, input, 1: asynchronous serial line; idles high.
REQ-006 SHALL have port rd_valid, output, 1: FIFO holds at least one byte.
REQ-007 SHALL have port rd_ready, input, 1: consumer accepts the byte.
REQ-008 SHALL have port rd_data, output, 8: oldest FIFO byte.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port parity_err, output, 1: one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-013 SHALL use a divider that counts 0..CLK_DIV-1, held at 0 in IDLE and BREAK; a tick occurs at CLK_DIV-1.
REQ-014 SHALL use a 4-bit phase counter of ticks per bit; the sample point is phase 7 (mid-bit).
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 In IDLE, synchronized rx = 0 SHALL cause a transition to START and clear the divider and phase counter.
REQ-017 In START, rx = 1 at the sample point SHALL be treated as a glitch and return the FSM to IDLE; otherwise the FSM SHALL enter DATA at phase 15.
REQ-018 In DATA, the FSM SHALL sample 8 bits LSB first at each sample point, then go to PARITY (macro defined) or STOP.
REQ-019 In STOP, at the sample point: rx = 1 with no error SHALL push the byte and go to IDLE (mid-stop resync); rx = 0 SHALL pulse frame_err, discard the byte and go to BREAK.
REQ-020 BREAK SHALL remain until synchronized rx = 1, then go to IDLE.
REQ-021 rd_valid SHALL assert the cycle after the push cycle if the FIFO was empty.
REQ-022 A byte SHALL be popped on rd_valid && rd_ready; rd_data SHALL be stable while rd_valid && !rd_ready.
REQ-023 A push to a full FIFO SHALL be dropped with an overrun pulse, except when a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-024 Bytes SHALL be delivered in arrival order; pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be FIFO_DEPTH+1 values wide.
REQ-025 Error pulses SHALL never coincide with a push of the same byte.

Reset
REQ-026 Asserting reset SHALL place the FSM in IDLE, clear the counters, shift register and FIFO, and drive rd_valid, frame_err, overrun and parity_err to 0 and rd_data to 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; the next byte SHALL be received only after a fresh start edge following reset release.

Configuration
REQ-028 With UART_RX_PARITY_EN defined, the frame SHALL be 11 bits with an even parity bit sampled in PARITY; a mismatch SHALL pulse parity_err, discard the byte and still check the stop bit.
REQ-029 Without UART_RX_PARITY_EN, the frame SHALL be 8N1 (10 bits), the PARITY state SHALL be unreachable and parity_err SHALL be constant 0.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, the SAMPLE_PHASE=7 and TICKS_PER_BIT=16 constants, and the data width 8.
REQ-031 The FIFO SHALL be a sub-module uart_rx_fifo (valid/ready pop, push/full, FIFO_DEPTH parameter); the FSM, synchronizer and divider SHALL reside in uart_rx_frame.

Verification (CLK_DIV=4, i.e. 64 clocks/bit)
REQ-032 Frame 0x55, rd_ready=1 -> rd_valid for exactly one cycle with rd_data=0x55, no error pulses.
REQ-033 rx low for 8 clocks then high -> no rd_valid and no frame_err; the FSM returns to IDLE.
REQ-034 Frame 0xA3 with stop bit 0, then line held low for 200 clocks, then frame 0x3C -> one frame_err, no push of 0xA3, rd_data=0x3C.
REQ-035 Five frames 0x01..0x05 with rd_ready=0, FIFO_DEPTH=4 -> overrun on the 5th; draining yields 0x01..0x04 in order.
REQ-036 Reset pulsed mid-data of 0xFF, then frame 0x12 -> only 0x12 is received; rd_valid=0 during reset.
REQ-037 With UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> parity_err pulse and no rd_valid; with parity bit 1 -> rd_data=0x07.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// Shared constants and FSM state type for the UART receive frame block.
// Used by uart_rx_frame and its FIFO (uart_rx_fifo).
package uart_rx_frame_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned TICKS_PER_BIT = 16;
  localparam logic [3:0]  SAMPLE_PHASE  = 4'd7;
  localparam logic [3:0]  LAST_PHASE    = 4'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: push/full on the write side, valid/ready on the read side.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop;
  logic              accept;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    pop      = rd_valid && rd_ready;
    accept   = push && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 16x oversampled 8N1 framing into a small FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int unsigned    DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  rx_state_e         state_q, state_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        phase_q, phase_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              tick;
  logic              at_sample;
  logic              at_last;
  logic              push;
  logic              fifo_full;

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (shift_q),
    .full    (fifo_full),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data (rd_data)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    rx_meta_d   = rx;
    rx_sync_d   = rx_meta_q;
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    tick        = (div_q == DIV_LAST);
    at_sample   = tick && (phase_q == SAMPLE_PHASE);
    at_last     = tick && (phase_q == LAST_PHASE);

    if (state_q == ST_IDLE || state_q == ST_BREAK) begin
      div_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
    if (tick) begin
      phase_d = phase_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        phase_d   = '0;
        bit_d     = '0;
        par_bad_d = 1'b0;
        if (!rx_sync_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (at_sample && rx_sync_q) begin
          state_d = ST_IDLE;
        end else if (at_last) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_sample) begin
          shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
        end
        if (at_last) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (at_sample && (rx_sync_q != ^shift_q)) begin
          par_bad_d = 1'b1;
        end
        if (at_last) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Decide at mid-stop so the next start edge is caught without slip.
        if (at_sample) begin
          if (rx_sync_q) begin
            push    = !par_bad_q;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    overrun_d = push && fifo_full && !(rd_valid && rd_ready);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      div_q       <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Pulse once, on the cycle after the parity bit is sampled wrong.
  always_comb begin
    parity_err_d = (state_q == ST_PARITY) && at_sample && (rx_sync_q != ^shift_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at CLK_DIV=4 (64 clocks per bit).
// Honours UART_RX_PARITY_EN for frame format and the parity test.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int BIT_CLKS = 64;

  logic       clock;
  logic       reset;
  logic       rx;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_errors = 0;

  int n_valid = 0;
  int n_ferr  = 0;
  int n_ovr   = 0;
  int n_perr  = 0;
  logic [7:0] got[$];

  uart_rx_frame #(
    .CLK_DIV(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rd_valid) n_valid++;
    if (rd_valid && rd_ready) got.push_back(rd_data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (parity_err) n_perr++;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cyc(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] d, input logic par_b, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_b);
    send_bit(stop_b);
    rx = 1'b1;
  endtask
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         gap;
    logic       exp_push;
    int         exp_ferr;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int g0, f0, v0, o0, p0;
    logic [7:0] exp_q[$];
    int exp_ferr;

    reset    = 1'b1;
    rx       = 1'b1;
    rd_ready = 1'b1;

    vecs[0] = '{8'h55, 1'b1, 20, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1,  8, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1,  8, 1'b1, 0};
    vecs[3] = '{8'h80, 1'b1, 30, 1'b1, 0};
    vecs[4] = '{8'hC3, 1'b0, 20, 1'b0, 1};
    vecs[5] = '{8'h01, 1'b1,  8, 1'b1, 0};
    vecs[6] = '{8'h5A, 1'b1, 12, 1'b1, 0};

    cyc(5);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b0;
    cyc(10);

    // table-driven single frames with rd_ready held high
    foreach (vecs[k]) begin
      g0 = got.size(); f0 = n_ferr; v0 = n_valid;
      send_frame(vecs[k].data, vecs[k].stop_b);
      cyc(vecs[k].gap);
      chk($sformatf("vec%0d_pushes", k), 32'(got.size() - g0), 32'(vecs[k].exp_push));
      chk($sformatf("vec%0d_valid_cycles", k), 32'(n_valid - v0), 32'(vecs[k].exp_push));
      chk($sformatf("vec%0d_frame_err", k), 32'(n_ferr - f0), 32'(vecs[k].exp_ferr));
      if (vecs[k].exp_push && got.size() > g0)
        chk($sformatf("vec%0d_data", k), 32'(got[g0]), 32'(vecs[k].data));
    end

    // start glitch: short low pulse must not start a frame
    g0 = got.size(); f0 = n_ferr; v0 = n_valid;
    rx = 1'b0; cyc(8); rx = 1'b1; cyc(200);
    chk("glitch_valid", 32'(n_valid - v0), 32'd0);
    chk("glitch_frame_err", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h5A, 1'b1); cyc(10);
    chk("after_glitch_pushes", 32'(got.size() - g0), 32'd1);
    if (got.size() > g0) chk("after_glitch_data", 32'(got[g0]), 32'h5A);

    // bad stop bit, long break, then a good frame
    g0 = got.size(); f0 = n_ferr;
    send_frame(8'hA3, 1'b0);
    rx = 1'b0; cyc(200); rx = 1'b1; cyc(20);
    send_frame(8'h3C, 1'b1); cyc(10);
    chk("break_frame_err", 32'(n_ferr - f0), 32'd1);
    chk("break_pushes", 32'(got.size() - g0), 32'd1);
    if (got.size() > g0) chk("break_data", 32'(got[g0]), 32'h3C);

    // overrun: five frames into a 4-deep FIFO with no consumer
    rd_ready = 1'b0;
    g0 = got.size(); o0 = n_ovr; f0 = n_ferr;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      cyc(8);
    end
    chk("ovr_pulses", 32'(n_ovr - o0), 32'd1);
    chk("ovr_rd_valid", 32'(rd_valid), 32'd1);
    chk("ovr_rd_data_stable", 32'(rd_data), 32'h01);
    chk("ovr_no_frame_err", 32'(n_ferr - f0), 32'd0);
    rd_ready = 1'b1;
    cyc(10);
    chk("drain_count", 32'(got.size() - g0), 32'd4);
    for (int i = 0; i < 4; i++)
      if (got.size() > g0 + i) chk($sformatf("drain_%0d", i), 32'(got[g0 + i]), 32'(i + 1));
    chk("drain_empty", 32'(rd_valid), 32'd0);

    // reset mid-data of 0xFF abandons the frame
    g0 = got.size(); f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    cyc(3);
    chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    cyc(BIT_CLKS * 6);
    send_frame(8'h12, 1'b1); cyc(10);
    chk("midreset_pushes", 32'(got.size() - g0), 32'd1);
    if (got.size() > g0) chk("midreset_data", 32'(got[g0]), 32'h12);
    chk("midreset_frame_err", 32'(n_ferr - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
    g0 = got.size(); p0 = n_perr; v0 = n_valid;
    send_frame_p(8'h07, 1'b0, 1'b1); cyc(10);
    chk("par_bad_pulse", 32'(n_perr - p0), 32'd1);
    chk("par_bad_valid", 32'(n_valid - v0), 32'd0);
    p0 = n_perr;
    send_frame_p(8'h07, 1'b1, 1'b1); cyc(10);
    chk("par_good_pulse", 32'(n_perr - p0), 32'd0);
    chk("par_good_pushes", 32'(got.size() - g0), 32'd1);
    if (got.size() > g0) chk("par_good_data", 32'(got[g0]), 32'h07);
`endif

    // randomized frames against a frame-level reference model
    g0 = got.size(); f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    exp_ferr = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic       s;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, s);
      if (s) exp_q.push_back(d);
      else exp_ferr++;
      cyc($urandom_range(8, 60));
    end
    cyc(10);
    chk("rand_count", 32'(got.size() - g0), 32'(exp_q.size()));
    chk("rand_frame_err", 32'(n_ferr - f0), 32'(exp_ferr));
    chk("rand_overrun", 32'(n_ovr - o0), 32'd0);
    chk("rand_parity_err", 32'(n_perr - p0), 32'd0);
    for (int i = 0; i < exp_q.size(); i++)
      if (got.size() > g0 + i) chk($sformatf("rand_data_%0d", i), 32'(got[g0 + i]), 32'(exp_q[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
